// File: rtl/instruction_fetcher_pkg.sv
// Shared definitions for the instruction fetch front end: word type,
// truth constants, fetch FSM encoding, reset PC default and the helpers
// that derive cache tag/index bit ranges from the index width.
// Optional feature macro: ICACHE_EN (instruction cache compiled in).
package instruction_fetcher_pkg;

  localparam int WORD_MSB = 31;
  localparam int WORD_LSB = 0;
  typedef logic [WORD_MSB:WORD_LSB] word_t;

  localparam word_t ZERO_WORD = '0;
  localparam logic  TRUE      = 1'b1;
  localparam logic  FALSE     = 1'b0;

  typedef enum logic {
    ST_FETCH    = 1'b0,
    ST_WAIT_MEM = 1'b1
  } fetch_state_t;

  localparam word_t DEFAULT_RESET_PC          = 32'h0000_0000;
  localparam int    DEFAULT_ICACHE_INDEX_BITS = 6;

  // Instructions are word aligned; the cache index starts right above the byte offset.
  localparam int INDEX_LSB = 2;

  function automatic int index_msb(input int index_bits);
    return INDEX_LSB + index_bits - 1;
  endfunction

  function automatic int tag_lsb(input int index_bits);
    return INDEX_LSB + index_bits;
  endfunction

  function automatic int tag_width(input int index_bits);
    return 30 - index_bits;
  endfunction

endpackage

// File: rtl/instruction_fetcher_if.sv
// Signal bundle between the fetcher and its neighbours: reorder-buffer
// rollback, memory controller request/response and decode delivery.
// master = fetcher side, slave = surrounding pipeline / memory side.
interface instruction_fetcher_if;
  import instruction_fetcher_pkg::*;

  logic  rob_rollback_in;
  word_t rob_rollback_pc_in;
  logic  mc_request_out;
  word_t mc_address_out;
  logic  mc_ready_in;
  word_t mc_instruction_in;
  logic  issue_stall_in;
  logic  inst_valid_out;
  word_t inst_out;
  word_t inst_pc_out;

  modport master (
    input  rob_rollback_in, rob_rollback_pc_in, mc_ready_in, mc_instruction_in, issue_stall_in,
    output mc_request_out, mc_address_out, inst_valid_out, inst_out, inst_pc_out
  );

  modport slave (
    output rob_rollback_in, rob_rollback_pc_in, mc_ready_in, mc_instruction_in, issue_stall_in,
    input  mc_request_out, mc_address_out, inst_valid_out, inst_out, inst_pc_out
  );
endinterface

// File: rtl/instruction_fetcher_icache.sv
// Direct-mapped one-word-per-line instruction cache. Lookup is purely
// combinational on the word address; fills land on the rising edge.
// Only the valid bits are reset; tag and data contents are don't-care
// until their line is marked valid.
module icache_direct_mapped
  import instruction_fetcher_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_ICACHE_INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] rd_word_addr,
  output logic        rd_hit,
  output word_t       rd_data,
  input  logic        wr_en,
  input  logic [29:0] wr_word_addr,
  input  word_t       wr_data
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int TAG_W = tag_width(INDEX_BITS);

  logic [DEPTH-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [DEPTH];
  word_t                 data_q [DEPTH];

  logic [INDEX_BITS-1:0] rd_idx;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_W-1:0]      rd_tag;
  logic [TAG_W-1:0]      wr_tag;

  assign rd_idx  = rd_word_addr[INDEX_BITS-1:0];
  assign rd_tag  = rd_word_addr[29:INDEX_BITS];
  assign wr_idx  = wr_word_addr[INDEX_BITS-1:0];
  assign wr_tag  = wr_word_addr[29:INDEX_BITS];

  assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx];

  // Valid bits: cleared only by reset, set by a fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= TRUE;
    end
  end

  // Tag and data storage, written on fill.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch front end: owns the PC, looks it up in the instruction cache,
// issues a single outstanding word fetch to the memory controller on a
// miss and delivers {instruction, pc} to decode. Rollback redirects the
// PC and wins over every other event in its cycle.
// Optional feature macro: ICACHE_EN. When undefined no cache is built and
// every instruction is fetched from memory.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int    ICACHE_INDEX_BITS = DEFAULT_ICACHE_INDEX_BITS,
  parameter word_t RESET_PC          = DEFAULT_RESET_PC
) (
  input logic                  clk,
  input logic                  rst,
  instruction_fetcher_if.master bus
);

  fetch_state_t state;
  word_t        pc;

  logic         lookup_hit;
  word_t        lookup_data;

`ifdef ICACHE_EN
  logic fill_en;

  // A fill is the memory response for the current pc, unless rollback discards it.
  assign fill_en = (state == ST_WAIT_MEM) && bus.mc_ready_in && !bus.rob_rollback_in;

  icache_direct_mapped #(
    .INDEX_BITS (ICACHE_INDEX_BITS)
  ) u_icache (
    .clk          (clk),
    .rst          (rst),
    .rd_word_addr (pc[WORD_MSB:INDEX_LSB]),
    .rd_hit       (lookup_hit),
    .rd_data      (lookup_data),
    .wr_en        (fill_en),
    .wr_word_addr (pc[WORD_MSB:INDEX_LSB]),
    .wr_data      (bus.mc_instruction_in)
  );
`else
  assign lookup_hit  = FALSE;
  assign lookup_data = ZERO_WORD;
`endif

  // Fetch FSM, PC and all registered outputs; pulses default low each cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= ST_FETCH;
      pc                 <= RESET_PC;
      bus.mc_request_out <= FALSE;
      bus.mc_address_out <= ZERO_WORD;
      bus.inst_valid_out <= FALSE;
      bus.inst_out       <= ZERO_WORD;
      bus.inst_pc_out    <= ZERO_WORD;
    end else begin
      bus.mc_request_out <= FALSE;
      bus.inst_valid_out <= FALSE;
      if (bus.rob_rollback_in) begin
        // Redirect; any same-cycle memory response is dropped along with the request.
        pc    <= bus.rob_rollback_pc_in & ~word_t'(3);
        state <= ST_FETCH;
      end else begin
        case (state)
          ST_FETCH: begin
            if (!bus.issue_stall_in) begin
              if (lookup_hit) begin
                bus.inst_valid_out <= TRUE;
                bus.inst_out       <= lookup_data;
                bus.inst_pc_out    <= pc;
                pc                 <= pc + 32'd4;
              end else begin
                bus.mc_request_out <= TRUE;
                bus.mc_address_out <= pc;
                state              <= ST_WAIT_MEM;
              end
            end
          end
          ST_WAIT_MEM: begin
            // Downstream keeps a slot for this fetch, so stall is not consulted here.
            if (bus.mc_ready_in) begin
              bus.inst_valid_out <= TRUE;
              bus.inst_out       <= bus.mc_instruction_in;
              bus.inst_pc_out    <= pc;
              pc                 <= pc + 32'd4;
              state              <= ST_FETCH;
            end
          end
          default: state <= ST_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench for instruction_fetcher. A reference model tracks the
// expected next PC and which word addresses are resident in a direct-mapped
// cache of 64 lines; memory contents are a fixed function of address.
module tb_instruction_fetcher;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instruction_fetcher_if bus ();

  instruction_fetcher #(
    .ICACHE_INDEX_BITS (6),
    .RESET_PC          (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int          checks = 0;
  int          errors = 0;
  int          n_req  = 0;
  logic [31:0] exp_pc = 32'h0;

  // Reference cache: which full word address each line currently holds.
  bit          line_valid [64];
  logic [31:0] line_addr  [64];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
`ifdef ICACHE_EN
    int idx;
    idx = int'((a / 4) % 64);
    return line_valid[idx] && (line_addr[idx] == a);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_fill(input logic [31:0] a);
`ifdef ICACHE_EN
    int idx;
    idx = int'((a / 4) % 64);
    line_valid[idx] = 1'b1;
    line_addr[idx]  = a;
`endif
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      line_valid[i] = 1'b0;
      line_addr[i]  = 32'h0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expect one instruction at exp_pc, answering a miss after a random delay.
  task automatic fetch_one();
    bit hit;
    int lat;
    hit = model_hit(exp_pc);
    step();
    if (hit) begin
      check("hit_valid", {31'h0, bus.inst_valid_out}, 32'h1);
      check("hit_pc",    bus.inst_pc_out, exp_pc);
      check("hit_inst",  bus.inst_out, mem_word(exp_pc));
      check("hit_noreq", {31'h0, bus.mc_request_out}, 32'h0);
    end else begin
      check("miss_req",     {31'h0, bus.mc_request_out}, 32'h1);
      check("miss_addr",    bus.mc_address_out, exp_pc);
      check("miss_novalid", {31'h0, bus.inst_valid_out}, 32'h0);
      n_req++;
      lat = $urandom_range(0, 3);
      for (int i = 0; i < lat; i++) begin
        step();
        check("wait_noreq",   {31'h0, bus.mc_request_out}, 32'h0);
        check("wait_novalid", {31'h0, bus.inst_valid_out}, 32'h0);
      end
      bus.mc_ready_in       = 1'b1;
      bus.mc_instruction_in = mem_word(exp_pc);
      step();
      bus.mc_ready_in       = 1'b0;
      bus.mc_instruction_in = $urandom;
      check("fill_valid", {31'h0, bus.inst_valid_out}, 32'h1);
      check("fill_pc",    bus.inst_pc_out, exp_pc);
      check("fill_inst",  bus.inst_out, mem_word(exp_pc));
      check("fill_noreq", {31'h0, bus.mc_request_out}, 32'h0);
      model_fill(exp_pc);
    end
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic rollback(input logic [31:0] tgt);
    bus.rob_rollback_in    = 1'b1;
    bus.rob_rollback_pc_in = tgt;
    step();
    bus.rob_rollback_in    = 1'b0;
    bus.rob_rollback_pc_in = $urandom;
    check("rb_novalid", {31'h0, bus.inst_valid_out}, 32'h0);
    check("rb_noreq",   {31'h0, bus.mc_request_out}, 32'h0);
    exp_pc = tgt & 32'hFFFF_FFFC;
  endtask

  task automatic stall_cycles(input int n);
    bus.issue_stall_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      check("stall_noreq",   {31'h0, bus.mc_request_out}, 32'h0);
      check("stall_novalid", {31'h0, bus.inst_valid_out}, 32'h0);
    end
    bus.issue_stall_in = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_before;
    bus.rob_rollback_in    = 1'b0;
    bus.rob_rollback_pc_in = 32'h0;
    bus.mc_ready_in        = 1'b0;
    bus.mc_instruction_in  = 32'h0;
    bus.issue_stall_in     = 1'b0;
    model_clear();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_req",   {31'h0, bus.mc_request_out}, 32'h0);
    check("rst_addr",  bus.mc_address_out, 32'h0);
    check("rst_valid", {31'h0, bus.inst_valid_out}, 32'h0);
    check("rst_inst",  bus.inst_out, 32'h0);
    check("rst_pc",    bus.inst_pc_out, 32'h0);
    rst = 1'b1;
    exp_pc = 32'h0;

    // Cold start 0x0, 0x4, then 0x8 answered in the same cycle as rollback to 0x40
    fetch_one();
    fetch_one();
    step();
    check("cold8_req",  {31'h0, bus.mc_request_out}, 32'h1);
    check("cold8_addr", bus.mc_address_out, 32'h8);
    step();
    bus.mc_ready_in        = 1'b1;
    bus.mc_instruction_in  = mem_word(32'h8);
    bus.rob_rollback_in    = 1'b1;
    bus.rob_rollback_pc_in = 32'h40;
    step();
    bus.mc_ready_in     = 1'b0;
    bus.rob_rollback_in = 1'b0;
    check("rbready_novalid", {31'h0, bus.inst_valid_out}, 32'h0);
    check("rbready_noreq",   {31'h0, bus.mc_request_out}, 32'h0);
    exp_pc = 32'h40;
    fetch_one();
    rollback(32'h8);
    fetch_one();

    // Loop 0x10..0x1C, re-executed via rollback
    rollback(32'h10);
    for (int i = 0; i < 4; i++) fetch_one();
    req_before = n_req;
    rollback(32'h10);
    for (int i = 0; i < 4; i++) fetch_one();
`ifdef ICACHE_EN
    check("loop2_reqs", n_req - req_before, 32'd0);
`else
    check("loop2_reqs", n_req - req_before, 32'd4);
`endif

    // Stall in FETCH, then resume at the held PC (one cached, one uncached)
    rollback(32'h14);
    stall_cycles(5);
    fetch_one();
    rollback(32'h80);
    stall_cycles(5);
    fetch_one();

    // PC wrap and forced alignment of the rollback target
    rollback(32'hFFFF_FFF9);
    for (int i = 0; i < 3; i++) fetch_one();
    check("wrap_pc", exp_pc, 32'h4);

    // Randomized redirects, runs and stalls
    for (int it = 0; it < 40; it++) begin
      rollback($urandom_range(0, 32'h3FF));
      if ($urandom_range(0, 3) == 0) stall_cycles($urandom_range(1, 3));
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) fetch_one();
    end

    // Reset in the middle of a miss
    rollback(32'h0);
    step();
    check("rstmiss_req", {31'h0, bus.mc_request_out}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("rstmiss_async_req",   {31'h0, bus.mc_request_out}, 32'h0);
    check("rstmiss_async_valid", {31'h0, bus.inst_valid_out}, 32'h0);
    check("rstmiss_async_inst",  bus.inst_out, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    exp_pc = 32'h0;

    // Aliasing 0x0 / 0x100 on line 0 after the valid bits were cleared
    req_before = n_req;
    fetch_one();
    rollback(32'h100);
    fetch_one();
    rollback(32'h0);
    fetch_one();
    check("alias_reqs", n_req - req_before, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
